// File: rtl/logic_op_pkg.sv
// Shared opcode and FSM encodings for the logic-op arbiter slice.
// Imported by logic_op_unit and logic_op_arbiter.
package logic_op_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_SEL  = 2'b10;
    localparam logic [1:0] OP_MASK = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/logic_op_arbiter_if.sv
// Request/response bundle between NREQ clients and the shared logic-op unit.
// Clients use the master modport; the arbiter uses the slave modport.
interface logic_op_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic [NREQ-1:0]       req_sel;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [WIDTH-1:0]      resp_data;

    modport master (
        output req_valid, req_op, req_a, req_b, req_sel, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_sel, resp_ready,
        output req_ready, resp_valid, resp_id, resp_data
    );

endinterface

// File: rtl/logic_op_unit.sv
// Combinational 4-function logic unit: AND, OR, select, mask.
// Used standalone as well as behind logic_op_arbiter.
module logic_op_unit
    import logic_op_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        unique case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_SEL:  y = sel ? a : b;
            OP_MASK: y = ({WIDTH{sel}} & a) | (a & b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic_op_unit among NREQ requesters.
// One op in flight: accept (IDLE) -> compute (EXEC) -> hold result (RESP).
module logic_op_arbiter
    import logic_op_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 4
) (
    input logic               clk,
    input logic               rst,
    logic_op_arbiter_if.slave bus
);

    localparam int unsigned IDW = $clog2(NREQ);

    state_e           state_q, state_d;
    logic [IDW-1:0]   last_grant_q;
    logic [IDW-1:0]   grant_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sel_q;
    logic [WIDTH-1:0] resp_data_q;
    logic [IDW-1:0]   resp_id_q;

    logic             any_valid;
    logic [IDW-1:0]   pick;
    logic [1:0]       op_mux;
    logic [WIDTH-1:0] a_mux;
    logic [WIDTH-1:0] b_mux;
    logic             sel_mux;
    logic [WIDTH-1:0] unit_y;

    // Rotate so that last_grant+1 sits at bit 0, take the lowest set bit,
    // then rotate the index back into requester numbering.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                               input logic [IDW-1:0]  last);
        logic [NREQ-1:0] rot;
        int unsigned     base;
        int unsigned     idx;
        logic            found;
        base  = (32'(last) + 1) % NREQ;
        idx   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rot[i] = valid[(base + i) % NREQ];
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && rot[i]) begin
                idx   = i;
                found = 1'b1;
            end
        end
        return IDW'((base + idx) % NREQ);
    endfunction

    assign any_valid = |bus.req_valid;
    assign pick      = rr_pick(bus.req_valid, last_grant_q);

    always_comb begin
        op_mux  = '0;
        a_mux   = '0;
        b_mux   = '0;
        sel_mux = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick == IDW'(i)) begin
                op_mux  = bus.req_op[2*i +: 2];
                a_mux   = bus.req_a[WIDTH*i +: WIDTH];
                b_mux   = bus.req_b[WIDTH*i +: WIDTH];
                sel_mux = bus.req_sel[i];
            end
        end
    end

    logic_op_unit #(
        .WIDTH (WIDTH)
    ) u_unit (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .sel (sel_q),
        .y   (unit_y)
    );

    // Next state and the combinational accept strobe.
    always_comb begin
        state_d       = state_q;
        bus.req_ready = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    bus.req_ready[pick] = 1'b1;
                    state_d             = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            grant_q      <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && any_valid) begin
                grant_q <= pick;
                op_q    <= op_mux;
                a_q     <= a_mux;
                b_q     <= b_mux;
                sel_q   <= sel_mux;
            end
            if (state_q == ST_EXEC) begin
                resp_data_q  <= unit_y;
                resp_id_q    <= grant_q;
                last_grant_q <= grant_q;
            end
        end
    end

    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_id    = resp_id_q;

`ifndef SYNTHESIS
    a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.req_ready));
    a_ready_idle_only: assert property (@(posedge clk) disable iff (rst)
        (state_q != ST_IDLE) |-> (bus.req_ready == '0));
`endif

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Randomized and directed bench for logic_op_arbiter against a
// transaction-level reference model.
module tb_logic_op_arbiter;
    import logic_op_pkg::*;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic_op_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    logic_op_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one transaction slot, cycles since accept, last grant.
    bit         m_busy;
    int         m_age;
    int         m_last;
    int         m_pend_id;
    logic [3:0] m_pend_data;
    int         m_hold_id;
    logic [3:0] m_hold_data;
    logic [3:0] obs_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_op(input logic [1:0] op, input logic [3:0] a,
                                          input logic [3:0] b, input logic s);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return s ? a : b;
            default: return (s ? a : 4'h0) | (a & b);
        endcase
    endfunction

    function automatic int ref_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= int'(NREQ); k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [1:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic s);
        bus.req_op[2*i +: 2] = op;
        bus.req_a[4*i +: 4]  = a;
        bus.req_b[4*i +: 4]  = b;
        bus.req_sel[i]       = s;
    endtask

    // Called just after a rising edge; drives, checks at the falling edge,
    // advances the model to the next rising edge.
    task automatic cycle(input logic [NREQ-1:0] v_in, input logic rr, input logic r,
                         input bit chk, output int g);
        logic [NREQ-1:0] v;
        logic [NREQ-1:0] exp_ready;
        int              p;
        v              = r ? '0 : v_in;
        bus.req_valid  = v;
        bus.resp_ready = rr;
        rst            = r;
        @(negedge clk);
        p         = ref_pick(v, m_last);
        exp_ready = '0;
        g         = -1;
        if (!m_busy && p >= 0) begin
            exp_ready[p] = 1'b1;
            g            = p;
        end
        obs_ready = bus.req_ready;
        if (chk) begin
            check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
            check("resp_valid", 32'(bus.resp_valid), 32'(m_busy && m_age >= 2));
            check("resp_data", 32'(bus.resp_data), 32'(m_hold_data));
            check("resp_id", 32'(bus.resp_id), 32'(m_hold_id));
        end
        if (r) begin
            m_busy      = 1'b0;
            m_age       = 0;
            m_last      = NREQ - 1;
            m_hold_id   = 0;
            m_hold_data = '0;
            g           = -1;
        end else if (g >= 0) begin
            m_pend_id   = g;
            m_pend_data = ref_op(bus.req_op[2*g +: 2], bus.req_a[4*g +: 4],
                                 bus.req_b[4*g +: 4], bus.req_sel[g]);
            m_busy      = 1'b1;
            m_age       = 1;
        end else if (m_busy && m_age == 1) begin
            m_hold_id   = m_pend_id;
            m_hold_data = m_pend_data;
            m_last      = m_pend_id;
            m_age       = 2;
        end else if (m_busy && rr) begin
            m_busy = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {logic [1:0] op; logic [3:0] a; logic [3:0] b; logic s; logic [3:0] y;} vec_t;
    vec_t ops[4] = '{
        '{2'd1, 4'hC, 4'hA, 1'b0, 4'hE},
        '{2'd2, 4'h3, 4'h5, 1'b0, 4'h5},
        '{2'd3, 4'h9, 4'h0, 1'b1, 4'h9},
        '{2'd3, 4'h9, 4'h3, 1'b0, 4'h1}
    };

    initial begin
        int g;
        int last_t;
        int t;
        logic [3:0] order[$];
        logic [3:0] exp_order[5];
        logic [NREQ-1:0] pend;

        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sel   = '0;
        bus.resp_ready = 1'b0;
        rst = 1'b1;
        m_busy = 1'b0; m_age = 0; m_last = NREQ - 1;
        m_hold_id = 0; m_hold_data = '0; m_pend_id = 0; m_pend_data = '0;

        cycle('0, 1'b0, 1'b1, 1'b0, g);
        cycle('0, 1'b0, 1'b1, 1'b1, g);
        cycle('0, 1'b0, 1'b0, 1'b1, g);

        // Single request from requester 0.
        set_req(0, 2'd0, 4'hC, 4'hA, 1'b0);
        cycle(4'b0001, 1'b1, 1'b0, 1'b1, g);
        check("t1_ready", 32'(obs_ready), 32'h1);
        cycle('0, 1'b1, 1'b0, 1'b1, g);
        check("t1_data", 32'(bus.resp_data), 32'h8);
        check("t1_valid", 32'(bus.resp_valid), 32'h1);
        cycle('0, 1'b1, 1'b0, 1'b1, g);

        // Every opcode through requester 2.
        foreach (ops[i]) begin
            set_req(2, ops[i].op, ops[i].a, ops[i].b, ops[i].s);
            cycle(4'b0100, 1'b1, 1'b0, 1'b1, g);
            cycle('0, 1'b1, 1'b0, 1'b1, g);
            check("t2_data", 32'(bus.resp_data), 32'(ops[i].y));
            check("t2_id", 32'(bus.resp_id), 32'd2);
            cycle('0, 1'b1, 1'b0, 1'b1, g);
        end

        // All requesters valid: grant order and spacing.
        cycle('0, 1'b1, 1'b1, 1'b1, g);
        exp_order = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
        last_t = -3;
        for (t = 0; t < 15; t++) begin
            cycle(4'hF, 1'b1, 1'b0, 1'b1, g);
            if (obs_ready != '0) begin
                check("t3_gap", 32'(t - last_t), 32'd3);
                last_t = t;
                order.push_back(obs_ready);
            end
        end
        check("t3_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5 && i < order.size(); i++) check("t3_order", 32'(order[i]), 32'(exp_order[i]));
        cycle('0, 1'b1, 1'b0, 1'b1, g);
        cycle('0, 1'b1, 1'b0, 1'b1, g);

        // Backpressure with other requesters waiting, then a glitch from req3.
        set_req(1, 2'd1, 4'h6, 4'h1, 1'b0);
        cycle(4'b0010, 1'b0, 1'b0, 1'b1, g);
        cycle('0, 1'b0, 1'b0, 1'b1, g);
        for (int i = 0; i < 5; i++) cycle(4'b0101, 1'b0, 1'b0, 1'b1, g);
        cycle(4'b1000, 1'b0, 1'b0, 1'b1, g);
        check("t4_held", 32'(bus.resp_data), 32'h7);
        cycle('0, 1'b1, 1'b0, 1'b1, g);
        cycle(4'b0101, 1'b1, 1'b0, 1'b1, g);
        check("t4_next", 32'(obs_ready), 32'h4);
        cycle('0, 1'b1, 1'b0, 1'b1, g);
        cycle('0, 1'b1, 1'b0, 1'b1, g);

        // Reset during EXEC discards the op; requester 1 wins afterwards.
        cycle(4'b0100, 1'b1, 1'b0, 1'b1, g);
        cycle('0, 1'b1, 1'b1, 1'b1, g);
        cycle(4'b1010, 1'b1, 1'b0, 1'b1, g);
        check("t5_first", 32'(obs_ready), 32'h2);
        check("t5_valid", 32'(bus.resp_valid), 32'h0);
        for (int i = 0; i < 4; i++) cycle(4'b1000, 1'b1, 1'b0, 1'b1, g);

        // Randomized traffic with holding requesters, drops, backpressure, resets.
        pend = '0;
        for (int c = 0; c < 800; c++) begin
            logic r;
            bus.req_op  = 8'($urandom);
            bus.req_a   = 16'($urandom);
            bus.req_b   = 16'($urandom);
            bus.req_sel = 4'($urandom);
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!pend[i] && $urandom_range(3) == 0) pend[i] = 1'b1;
                else if (pend[i] && $urandom_range(15) == 0) pend[i] = 1'b0;
            end
            r = ($urandom_range(99) == 0);
            if (r) pend = '0;
            cycle(pend, 1'($urandom_range(9) < 7), r, 1'b1, g);
            if (g >= 0) pend[g] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
